trade_risk_gate: RTL and testbench

Pre-trade risk gate sitting directly upstream of the upstream cache FSM (`dm_cache_fsm_upstream`). It accepts one order or limit-update command at a time and reads the client's cache word (`[31:16]` max allowed, `[15:0]` accumulated). For orders it checks `accumulated + qty <= max`, posts the accumulation write back through the cache, and returns an accept/reject decision. It is the only master of `cpu_req`.

---
 rtl/trade_risk_gate.sv | 225 ++++++++++++++++++++++
 tb/tb_trade_risk_gate.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trade_risk_gate.sv
// trade_risk_gate: pre-trade risk gate that owns the upstream cache request port.
// Reads a client's {max, accumulated} word, checks acc+qty <= max, posts the accumulation and returns a decision.
package trade_risk_gate_pkg;

    typedef struct packed {
        logic [31:0] rdindex;
        logic [31:0] data;
        logic        rw;
        logic        valid;
    } cpu_req_type;

    typedef struct packed {
        logic [31:0] data;
        logic        ready;
    } cpu_result_type;

endpackage

module trade_risk_gate
    import trade_risk_gate_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned CLIENT_W    = 10
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_order_valid,
    output logic                o_order_ready,
    input  logic [CLIENT_W-1:0] i_order_client,
    input  logic [15:0]         i_order_qty,
    input  logic                i_order_set_max,
    output logic                o_dec_valid,
    input  logic                i_dec_ready,
    output logic                o_dec_accept,
    output logic [1:0]          o_dec_reason,
    output logic [CLIENT_W-1:0] o_dec_client,
    output cpu_req_type         o_cpu_req,
    input  cpu_result_type      i_cpu_res,
    output logic [15:0]         o_accept_cnt,
    output logic [15:0]         o_reject_cnt
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] RSN_OK      = 2'd0;
    localparam logic [1:0] RSN_OVER    = 2'd1;
    localparam logic [1:0] RSN_MAX_BAD = 2'd2;
    localparam logic [1:0] RSN_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CHECK,
        S_WR,
        S_RESP
    } state_t;

    state_t              r_state;
    logic [CLIENT_W-1:0] r_client;
    logic [15:0]         r_qty;
    logic [31:0]         r_word;
    logic [TMO_W-1:0]    r_tmo;
    logic                r_order_ready;
    logic                r_dec_valid;
    logic                r_dec_accept;
    logic [1:0]          r_dec_reason;
    logic [CLIENT_W-1:0] r_dec_client;
    cpu_req_type         r_cpu_req;
    logic [15:0]         r_accept_cnt;
    logic [15:0]         r_reject_cnt;

    logic [31:0]         w_idx_in;
    logic [31:0]         w_idx_reg;
    logic [16:0]         w_sum;
    logic                w_tmo_hit;

    // Client ID lands on the cache index field, one 16-byte line per client.
    assign w_idx_in  = 32'({i_order_client, 4'b0000});
    assign w_idx_reg = 32'({r_client, 4'b0000});

    // 17-bit sum so an accumulation overflowing 16 bits is caught as over-limit.
    assign w_sum     = {1'b0, r_word[15:0]} + {1'b0, r_qty};
    assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_client      <= '0;
            r_qty         <= '0;
            r_word        <= '0;
            r_tmo         <= '0;
            r_order_ready <= 1'b1;
            r_dec_valid   <= 1'b0;
            r_dec_accept  <= 1'b0;
            r_dec_reason  <= RSN_OK;
            r_dec_client  <= '0;
            r_cpu_req     <= '0;
            r_accept_cnt  <= '0;
            r_reject_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_order_valid) begin
                        r_order_ready <= 1'b0;
                        r_client      <= i_order_client;
                        r_qty         <= i_order_qty;
                        r_dec_client  <= i_order_client;
                        r_tmo         <= '0;
                        if (i_order_set_max) begin
                            if (i_order_qty > 16'd1) begin
                                r_cpu_req <= '{rdindex: w_idx_in,
                                               data:    {i_order_qty, 16'h0000},
                                               rw:      1'b1,
                                               valid:   1'b1};
                                r_state   <= S_WR;
                            end else begin
                                // A max of 0 or 1 is never written to the cache.
                                r_dec_valid  <= 1'b1;
                                r_dec_accept <= 1'b0;
                                r_dec_reason <= RSN_MAX_BAD;
                                r_state      <= S_RESP;
                            end
                        end else begin
                            r_cpu_req <= '{rdindex: w_idx_in,
                                           data:    32'h0000_0000,
                                           rw:      1'b0,
                                           valid:   1'b1};
                            r_state   <= S_RD;
                        end
                    end
                end

                S_RD: begin
                    if (i_cpu_res.ready) begin
                        r_word    <= i_cpu_res.data;
                        r_cpu_req <= '0;
                        r_state   <= S_CHECK;
                    end else if (w_tmo_hit) begin
                        r_cpu_req    <= '0;
                        r_dec_valid  <= 1'b1;
                        r_dec_accept <= 1'b0;
                        r_dec_reason <= RSN_TIMEOUT;
                        r_state      <= S_RESP;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end

                S_CHECK: begin
                    if (r_word[31:16] == 16'h0000) begin
                        r_dec_valid  <= 1'b1;
                        r_dec_accept <= 1'b0;
                        r_dec_reason <= RSN_MAX_BAD;
                        r_state      <= S_RESP;
                    end else if (w_sum > {1'b0, r_word[31:16]}) begin
                        r_dec_valid  <= 1'b1;
                        r_dec_accept <= 1'b0;
                        r_dec_reason <= RSN_OVER;
                        r_state      <= S_RESP;
                    end else begin
                        // Upper half <= 1 tells the cache to add data[15:0] to the accumulator.
                        r_cpu_req <= '{rdindex: w_idx_reg,
                                       data:    {16'h0000, r_qty},
                                       rw:      1'b1,
                                       valid:   1'b1};
                        r_tmo     <= '0;
                        r_state   <= S_WR;
                    end
                end

                S_WR: begin
                    if (i_cpu_res.ready) begin
                        r_cpu_req    <= '0;
                        r_dec_valid  <= 1'b1;
                        r_dec_accept <= 1'b1;
                        r_dec_reason <= RSN_OK;
                        r_state      <= S_RESP;
                    end else if (w_tmo_hit) begin
                        r_cpu_req    <= '0;
                        r_dec_valid  <= 1'b1;
                        r_dec_accept <= 1'b0;
                        r_dec_reason <= RSN_TIMEOUT;
                        r_state      <= S_RESP;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end

                S_RESP: begin
                    if (i_dec_ready) begin
                        r_dec_valid   <= 1'b0;
                        r_order_ready <= 1'b1;
                        r_state       <= S_IDLE;
                        if (r_dec_accept) begin
                            if (r_accept_cnt != 16'hFFFF) begin
                                r_accept_cnt <= r_accept_cnt + 16'd1;
                            end
                        end else begin
                            if (r_reject_cnt != 16'hFFFF) begin
                                r_reject_cnt <= r_reject_cnt + 16'd1;
                            end
                        end
                    end
                end

                default: begin
                    r_cpu_req     <= '0;
                    r_dec_valid   <= 1'b0;
                    r_order_ready <= 1'b1;
                    r_state       <= S_IDLE;
                end
            endcase
        end
    end

    assign o_order_ready = r_order_ready;
    assign o_dec_valid   = r_dec_valid;
    assign o_dec_accept  = r_dec_accept;
    assign o_dec_reason  = r_dec_reason;
    assign o_dec_client  = r_dec_client;
    assign o_cpu_req     = r_cpu_req;
    assign o_accept_cnt  = r_accept_cnt;
    assign o_reject_cnt  = r_reject_cnt;

endmodule

// File: tb/tb_trade_risk_gate.sv
// Bench for trade_risk_gate: small cache responder, decision model from the limit rules,
// per-cycle compare process and directed commands with hand-computed decisions and latencies.
module tb_trade_risk_gate;
    import trade_risk_gate_pkg::*;

    localparam int unsigned TMO = 64;
    localparam int unsigned CW  = 10;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           order_valid = 1'b0;
    logic           order_ready;
    logic [CW-1:0]  order_client = '0;
    logic [15:0]    order_qty = '0;
    logic           order_set_max = 1'b0;
    logic           dec_valid;
    logic           dec_ready = 1'b0;
    logic           dec_accept;
    logic [1:0]     dec_reason;
    logic [CW-1:0]  dec_client;
    cpu_req_type    cpu_req;
    cpu_result_type cpu_res = '0;
    logic [15:0]    accept_cnt;
    logic [15:0]    reject_cnt;

    int errors = 0;
    int checks = 0;

    trade_risk_gate #(.TIMEOUT_CYC(TMO), .CLIENT_W(CW)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_order_valid  (order_valid),
        .o_order_ready  (order_ready),
        .i_order_client (order_client),
        .i_order_qty    (order_qty),
        .i_order_set_max(order_set_max),
        .o_dec_valid    (dec_valid),
        .i_dec_ready    (dec_ready),
        .o_dec_accept   (dec_accept),
        .o_dec_reason   (dec_reason),
        .o_dec_client   (dec_client),
        .o_cpu_req      (cpu_req),
        .i_cpu_res      (cpu_res),
        .o_accept_cnt   (accept_cnt),
        .o_reject_cnt   (reject_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cache responder: ready pulses in the second cycle of a request unless withheld.
    logic [31:0] mem [0:1023];
    logic        withhold = 1'b0;
    int          vcnt = 0;
    int          last_len = 0;

    always @(negedge clk) begin
        logic [9:0] idx;
        if (cpu_req.valid && !rst) begin
            vcnt++;
            idx = cpu_req.rdindex[13:4];
            if (vcnt == 2 && !withhold) begin
                cpu_res.ready <= 1'b1;
                if (cpu_req.rw) begin
                    if (cpu_req.data[31:16] > 16'd1) mem[idx][31:16] = cpu_req.data[31:16];
                    else mem[idx][15:0] = mem[idx][15:0] + cpu_req.data[15:0];
                end else begin
                    cpu_res.data <= mem[idx];
                end
            end else begin
                cpu_res.ready <= 1'b0;
            end
        end else begin
            if (vcnt != 0) last_len = vcnt;
            vcnt = 0;
            cpu_res.ready <= 1'b0;
        end
    end

    // Model state: expectations for the command in flight and the decision counters.
    logic        run_chk = 1'b0;
    logic        m_exp_acc = 1'b0;
    logic [1:0]  m_exp_rsn = 2'd0;
    logic [9:0]  m_exp_client = '0;
    logic [31:0] exp_idx = '0;
    logic [31:0] exp_wdata = '0;
    int          m_acc = 0;
    int          m_rej = 0;
    int          valid_seen = 0;
    int          wr_seen = 0;
    cpu_req_type prev_req = '0;

    function automatic void predict(input logic sm, input logic [15:0] q, input logic [31:0] w,
                                    output logic acc, output logic [1:0] rsn,
                                    output logic wr, output logic [31:0] wd);
        int unsigned mx, a;
        mx = w[31:16];
        a  = w[15:0];
        acc = 1'b0; rsn = 2'd0; wr = 1'b0; wd = 32'h0;
        if (sm) begin
            if (q <= 16'd1) rsn = 2'd2;
            else begin acc = 1'b1; wr = 1'b1; wd = {q, 16'h0000}; end
        end else if (mx == 0) begin
            rsn = 2'd2;
        end else if (a + int'(q) > mx) begin
            rsn = 2'd1;
        end else begin
            acc = 1'b1; wr = 1'b1; wd = {16'h0000, q};
        end
    endfunction

    always @(posedge clk) begin
        if (!rst && run_chk && dec_valid && dec_ready) begin
            if (m_exp_acc) begin if (m_acc < 65535) m_acc++; end
            else begin if (m_rej < 65535) m_rej++; end
        end
    end

    // Per-cycle compare of DUT outputs against the model.
    always @(negedge clk) begin
        if (run_chk && !rst) begin
            chk("accept_cnt", 32'(accept_cnt), 32'(m_acc));
            chk("reject_cnt", 32'(reject_cnt), 32'(m_rej));
            if (cpu_req.valid) begin
                valid_seen++;
                chk("req_index", cpu_req.rdindex, exp_idx);
                if (cpu_req.rw) begin
                    wr_seen++;
                    chk("req_wdata", cpu_req.data, exp_wdata);
                end
                if (prev_req.valid) chk("req_stable", 32'(cpu_req == prev_req), 32'd1);
            end
            if (order_ready) chk("idle_no_req", 32'(cpu_req.valid), 32'd0);
            if (dec_valid) begin
                chk("dec_accept", 32'(dec_accept), 32'(m_exp_acc));
                chk("dec_reason", 32'(dec_reason), 32'(m_exp_rsn));
                chk("dec_client", 32'(dec_client), 32'(m_exp_client));
                chk("resp_not_ready", 32'(order_ready), 32'd0);
                chk("resp_no_req", 32'(cpu_req.valid), 32'd0);
            end
        end
        prev_req = cpu_req;
    end

    task automatic do_cmd(input logic [9:0] c, input logic [15:0] q, input logic sm,
                          input logic h_acc, input logic [1:0] h_rsn, input int h_lat, input int hold);
        logic e_acc, e_wr, e_cache;
        logic [1:0] e_rsn;
        logic [31:0] e_wd;
        int lat;
        predict(sm, q, mem[c], e_acc, e_rsn, e_wr, e_wd);
        e_cache = !(sm && q <= 16'd1);
        if (withhold && e_cache) begin
            e_acc = 1'b0; e_rsn = 2'd3; e_wr = sm;
        end
        @(negedge clk);
        m_exp_acc = e_acc; m_exp_rsn = e_rsn; m_exp_client = c;
        exp_idx = 32'({c, 4'b0000}); exp_wdata = e_wd;
        valid_seen = 0; wr_seen = 0;
        chk("order_ready_idle", 32'(order_ready), 32'd1);
        order_client = c; order_qty = q; order_set_max = sm; order_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        order_valid = 1'b0;
        lat = 1;
        while (!dec_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        chk("dec_seen", 32'(dec_valid), 32'd1);
        chk("hand_accept", 32'(dec_accept), 32'(h_acc));
        chk("hand_reason", 32'(dec_reason), 32'(h_rsn));
        chk("latency", 32'(lat), 32'(h_lat));
        chk("wr_issued", 32'(wr_seen != 0), 32'(e_wr));
        chk("cache_used", 32'(valid_seen != 0), 32'(e_cache));
        for (int i = 0; i < hold; i++) begin
            order_client = c ^ 10'd1; order_qty = 16'd5; order_set_max = 1'b0; order_valid = 1'b1;
            @(negedge clk);
            chk("hold_not_ready", 32'(order_ready), 32'd0);
            chk("hold_valid", 32'(dec_valid), 32'd1);
        end
        order_valid = 1'b0;
        dec_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dec_ready = 1'b0;
        chk("post_hs_valid", 32'(dec_valid), 32'd0);
        chk("post_hs_ready", 32'(order_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[5]  = 32'h0000_00F0;
        mem[9]  = 32'hFFFF_FFF0;
        mem[3]  = 32'h0010_0008;
        repeat (3) @(negedge clk);
        chk("rst_order_ready", 32'(order_ready), 32'd1);
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_dec_accept", 32'(dec_accept), 32'd0);
        chk("rst_dec_reason", 32'(dec_reason), 32'd0);
        chk("rst_dec_client", 32'(dec_client), 32'd0);
        chk("rst_cpu_req", 32'(cpu_req != '0), 32'd0);
        chk("rst_counters", 32'({accept_cnt, reject_cnt}), 32'd0);
        rst = 1'b0;
        run_chk = 1'b1;

        do_cmd(10'd5, 16'h0100, 1'b1, 1'b1, 2'd0, 3, 0);
        chk("mem5_max", mem[5], 32'h0100_00F0);
        do_cmd(10'd5, 16'h0010, 1'b0, 1'b1, 2'd0, 6, 0);
        chk("mem5_acc", mem[5], 32'h0100_0100);
        do_cmd(10'd5, 16'h0001, 1'b0, 1'b0, 2'd1, 4, 0);
        do_cmd(10'd7, 16'h0003, 1'b0, 1'b0, 2'd2, 4, 0);
        do_cmd(10'd7, 16'h0001, 1'b1, 1'b0, 2'd2, 1, 0);
        do_cmd(10'd9, 16'h0020, 1'b0, 1'b0, 2'd1, 4, 0);
        do_cmd(10'd5, 16'h0000, 1'b0, 1'b1, 2'd0, 6, 0);
        chk("mem5_qty0", mem[5], 32'h0100_0100);
        do_cmd(10'd3, 16'h0008, 1'b0, 1'b1, 2'd0, 6, 0);
        do_cmd(10'd3, 16'h0001, 1'b0, 1'b0, 2'd1, 4, 0);
        do_cmd(10'd3, 16'h0000, 1'b0, 1'b1, 2'd0, 6, 10);
        chk("accept_total", 32'(accept_cnt), 32'd5);

        withhold = 1'b1;
        do_cmd(10'd5, 16'h0001, 1'b0, 1'b0, 2'd3, 65, 0);
        chk("rd_timeout_len", 32'(last_len), 32'(TMO));
        do_cmd(10'd11, 16'h0005, 1'b1, 1'b0, 2'd3, 65, 0);
        chk("wr_timeout_len", 32'(last_len), 32'(TMO));
        chk("mem11_untouched", mem[11], 32'h0);
        chk("reject_total", 32'(reject_cnt), 32'd7);

        // Reset in the middle of a (stalled) write.
        @(negedge clk);
        exp_idx = 32'({10'd12, 4'b0000}); exp_wdata = 32'h0050_0000;
        order_client = 10'd12; order_qty = 16'h0050; order_set_max = 1'b1; order_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        order_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("in_wr", 32'({cpu_req.valid, cpu_req.rw}), 32'd3);
        run_chk = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_order_ready", 32'(order_ready), 32'd1);
        chk("mid_rst_dec", 32'({dec_valid, dec_accept, dec_reason}), 32'd0);
        chk("mid_rst_client", 32'(dec_client), 32'd0);
        chk("mid_rst_req", 32'(cpu_req != '0), 32'd0);
        chk("mid_rst_cnt", 32'({accept_cnt, reject_cnt}), 32'd0);
        m_acc = 0; m_rej = 0;
        @(negedge clk);
        rst = 1'b0;
        withhold = 1'b0;
        run_chk = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("no_dec_after_rst", 32'(dec_valid), 32'd0);
        end

        // Reject counter saturation.
        @(negedge clk);
        run_chk = 1'b0;
        force dut.r_reject_cnt = 16'hFFFE;
        m_rej = 65534;
        @(negedge clk);
        release dut.r_reject_cnt;
        run_chk = 1'b1;
        do_cmd(10'd1, 16'h0000, 1'b1, 1'b0, 2'd2, 1, 0);
        chk("rej_sat_reach", 32'(reject_cnt), 32'h0000_FFFF);
        do_cmd(10'd1, 16'h0001, 1'b1, 1'b0, 2'd2, 1, 0);
        chk("rej_sat_hold", 32'(reject_cnt), 32'h0000_FFFF);
        chk("acc_after_sat", 32'(accept_cnt), 32'd0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
